// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of a hart.
// One outstanding transaction; data has priority, bounded by a fetch starvation counter.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              own_data_q, own_data_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              if_gnt;
  logic              d_gnt;
  logic              fetch_wins;
  logic              unused_addr_lsbs;

  // Memory is word addressed; the byte offset is carried by the lane mask.
  assign unused_addr_lsbs = ^{i_if_addr[1:0], i_d_addr[1:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    own_data_d  = own_data_q;
    mem_addr_d  = mem_addr_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    fetch_wins  = i_if_req && (!i_d_req || (starve_q >= LIMIT));

    case (state_q)
      S_IDLE: begin
        if (fetch_wins) begin
          if_gnt      = 1'b1;
          state_d     = S_WAIT;
          own_data_d  = 1'b0;
          mem_addr_d  = {i_if_addr[31:2], 2'b00};
          mem_ren_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_wdata_d = 32'h0;
          mem_mask_d  = 4'b1111;
          starve_d    = '0;
        end else if (i_d_req) begin
          d_gnt       = 1'b1;
          state_d     = S_WAIT;
          own_data_d  = 1'b1;
          mem_addr_d  = {i_d_addr[31:2], 2'b00};
          mem_ren_d   = !i_d_wen;
          mem_wen_d   = i_d_wen;
          mem_wdata_d = i_d_wdata;
          mem_mask_d  = i_d_mask;
          starve_d    = i_if_req ? sat_inc(starve_q) : '0;
        end else begin
          starve_d    = '0;
        end
      end
      S_WAIT: begin
        // Completion: strobes drop at once, the owner sees its response next cycle.
        if (i_mem_ack) begin
          state_d   = S_IDLE;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          if (own_data_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_wen_q ? 32'h0 : i_mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = i_mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      own_data_q  <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_mask_q  <= 4'h0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      own_data_q  <= own_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Grants are combinational, so they are masked while reset is held.
  assign o_if_gnt    = if_gnt & i_rst_n;
  assign o_d_gnt     = d_gnt & i_rst_n;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rvalid  = d_rvalid_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_ren   = mem_ren_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_mask  = mem_mask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_wen;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wen(d_wen), .i_d_wdata(d_wdata),
    .i_d_mask(d_mask), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Backing store seen by the memory responder, and the model's own copy.
  logic [31:0] bmem [logic [29:0]];
  logic [31:0] refm [logic [29:0]];

  function automatic logic [31:0] rd_bmem(input logic [29:0] w);
    return bmem.exists(w) ? bmem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] rd_refm(input logic [29:0] w);
    return refm.exists(w) ? refm[w] : init_word(w);
  endfunction

  // Memory responder: acks `lat` cycles after a strobe appears, one-cycle pulse.
  int          lat = 1;
  bit          auto_mem = 1'b1;
  bit          stray_ack = 1'b0;
  int          mcnt;
  logic [29:0] mw;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    mcnt = 0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (!auto_mem) begin
        mem_ack = stray_ack;
        mcnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        mcnt = 0;
      end else if (mem_ren || mem_wen) begin
        mcnt++;
        if (mcnt >= lat) begin
          mw = mem_addr[31:2];
          mem_ack = 1'b1;
          mcnt = 0;
          if (mem_wen) bmem[mw] = merge(rd_bmem(mw), mem_wdata, mem_mask);
          else mem_rdata = rd_bmem(mw);
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chkb({tag, "_if_gnt"}, if_gnt, 1'b0);
    chkb({tag, "_d_gnt"}, d_gnt, 1'b0);
    chkb({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    chkb({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chkb({tag, "_mem_ren"}, mem_ren, 1'b0);
    chkb({tag, "_mem_wen"}, mem_wen, 1'b0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_mask"}, 32'(mem_mask), 32'h0);
  endtask

  // Field order: is_d, wen, addr, wdata, mask, lat, pre, exp_addr, exp_mask, exp_rdata, exp_word
  typedef struct {
    bit          is_d;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          lat;
    logic [31:0] pre;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic run_vec(input string tag, input vec_t v);
    int  took;
    bit  seen;
    lat = v.lat;
    bmem[v.addr[31:2]] = v.pre;
    cyc();
    if (v.is_d) begin
      d_req = 1'b1; d_addr = v.addr; d_wen = v.wen; d_wdata = v.wdata; d_mask = v.mask;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chkb({tag, "_if_gnt"}, if_gnt, !v.is_d);
    chkb({tag, "_d_gnt"}, d_gnt, v.is_d);
    cyc();
    if_req = 1'b0;
    d_req = 1'b0;
    chk({tag, "_mem_addr"}, mem_addr, v.exp_addr);
    chkb({tag, "_mem_ren"}, mem_ren, !v.wen);
    chkb({tag, "_mem_wen"}, mem_wen, v.wen);
    chk({tag, "_mem_mask"}, 32'(mem_mask), 32'(v.exp_mask));
    if (v.wen) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
    seen = 1'b0;
    took = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if ((v.is_d ? d_rvalid : if_rvalid) === 1'b1) begin
        seen = 1'b1;
        took = k;
        break;
      end
      chkb({tag, "_ren_held"}, mem_ren, !v.wen);
    end
    chkb({tag, "_rvalid_seen"}, seen, 1'b1);
    if (!seen) return;
    chk({tag, "_latency"}, 32'(took), 32'(v.lat));
    chk({tag, "_rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    chkb({tag, "_other_rvalid"}, v.is_d ? if_rvalid : d_rvalid, 1'b0);
    chkb({tag, "_strobe_off"}, mem_ren | mem_wen, 1'b0);
    chk({tag, "_mem_word"}, rd_bmem(v.addr[31:2]), v.exp_word);
    cyc();
    chkb({tag, "_pulse_end"}, v.is_d ? d_rvalid : if_rvalid, 1'b0);
    chk({tag, "_rdata_hold"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
  endtask

  // Randomized-run state: requesters and a transaction-level model.
  bit          if_pend, d_pend, d_w;
  logic [31:0] if_a, d_a, d_wd;
  logic [3:0]  d_m;
  bit          m_busy, m_owner_d, m_store;
  logic [31:0] m_addr, m_wdata, m_exp;
  logic [3:0]  m_mask;
  int          m_wins;
  bit          e_if, e_d, e_ifv, e_dv, seen_if, seen_d;
  logic [31:0] last_if, last_d;
  int          ng, n_ifv, n_dv;
  bit          got;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h104, 32'h0, 4'hF, 2, 32'hDEADBEEF, 32'h104, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h2003, 32'hAB000000, 4'b1000, 1, 32'h11223344, 32'h2000, 4'b1000, 32'h0, 32'hAB223344};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1, 32'hCAFEF00D, 32'h200, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 32'h300, 32'hFFFFFFFF, 4'h0, 3, 32'h55AA55AA, 32'h300, 4'h0, 32'h0, 32'h55AA55AA};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 4'hF, 4, 32'h0F0F0F0F, 32'hFFFFFFFC, 4'hF, 32'h0F0F0F0F, 32'h0F0F0F0F};
    vecs[5] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 2, 32'h0, 32'h40, 4'hF, 32'h0, 32'h12345678};
    vecs[6] = '{1'b1, 1'b1, 32'h42, 32'hABCD0000, 4'b1100, 1, 32'h12345678, 32'h40, 4'b1100, 32'h0, 32'hABCD5678};
    vecs[7] = '{1'b1, 1'b0, 32'h1001, 32'h0, 4'b0011, 2, 32'h89ABCDEF, 32'h1000, 4'b0011, 32'h89ABCDEF, 32'h89ABCDEF};

    // Reset with both requests raised: everything must stay 0.
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_addr = 32'h200; d_wen = 1'b0; d_wdata = 32'h0; d_mask = 4'hF;
    #2;
    all_zero("rst");
    cyc();
    all_zero("rst_edge");
    if_req = 1'b0;
    d_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();

    for (int i = 0; i < NV; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests: data first, fetch granted in the response cycle.
    lat = 1;
    cyc();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_addr = 32'h200; d_wen = 1'b0; d_mask = 4'hF;
    #1;
    chkb("sim_d_gnt", d_gnt, 1'b1);
    chkb("sim_if_gnt", if_gnt, 1'b0);
    cyc();
    d_req = 1'b0;
    chkb("sim_wait_if_gnt", if_gnt, 1'b0);
    n_ifv = 0; n_dv = 0; got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (d_rvalid) begin
        n_dv++;
        got = 1'b1;
        chkb("sim_if_gnt_on_resp", if_gnt, 1'b1);
        chk("sim_d_rdata", d_rdata, 32'hCAFEF00D);
        break;
      end
    end
    chkb("sim_d_resp_seen", got, 1'b1);
    cyc();
    if_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (if_rvalid) n_ifv++;
      if (d_rvalid) n_dv++;
      cyc();
    end
    chk("sim_if_resp_count", 32'(n_ifv), 32'd1);
    chk("sim_d_resp_count", 32'(n_dv), 32'd1);
    chk("sim_if_rdata", if_rdata, 32'hDEADBEEF);

    // Starvation: both held with latency 1, expect D D D D F repeating.
    lat = 1;
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_addr = 32'h80; d_wen = 1'b0; d_mask = 4'hF;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      #1;
      if (if_gnt || d_gnt) begin
        chk($sformatf("starve_g%0d", ng), 32'({if_gnt, d_gnt}), (ng % 5 == 4) ? 32'd2 : 32'd1);
        ng++;
      end
      cyc();
    end
    chk("starve_grants", 32'(ng), 32'd10);
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (4) cyc();

    // Ack while data request pending: response and next grant coincide.
    lat = 2;
    bmem[30'h180] = 32'h7777AAAA;
    bmem[30'h181] = 32'h12345678;
    d_req = 1'b1; d_addr = 32'h600; d_wen = 1'b0; d_mask = 4'hF;
    #1;
    chkb("bb_gnt1", d_gnt, 1'b1);
    cyc();
    d_addr = 32'h604; d_wen = 1'b1; d_wdata = 32'h0000BEEF; d_mask = 4'b0011;
    chkb("bb_wait_gnt", d_gnt, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (d_rvalid) begin
        got = 1'b1;
        chkb("bb_gnt2_with_rvalid", d_gnt, 1'b1);
        chk("bb_rdata1", d_rdata, 32'h7777AAAA);
        break;
      end
    end
    chkb("bb_resp1_seen", got, 1'b1);
    cyc();
    d_req = 1'b0;
    chkb("bb_mem_wen", mem_wen, 1'b1);
    chkb("bb_mem_ren", mem_ren, 1'b0);
    chk("bb_mem_addr", mem_addr, 32'h604);
    chk("bb_mem_wdata", mem_wdata, 32'h0000BEEF);
    chk("bb_mem_mask", 32'(mem_mask), 32'h3);
    chk("bb_rdata_hold", d_rdata, 32'h7777AAAA);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (d_rvalid) begin
        got = 1'b1;
        break;
      end
    end
    chkb("bb_resp2_seen", got, 1'b1);
    chk("bb_rdata2", d_rdata, 32'h0);
    chk("bb_mem_word", rd_bmem(30'h181), 32'h1234BEEF);
    repeat (2) cyc();

    // Reset in the middle of a transaction.
    lat = 6;
    if_req = 1'b1; if_addr = 32'h700;
    #1;
    chkb("rw_gnt", if_gnt, 1'b1);
    cyc();
    if_req = 1'b0;
    cyc();
    chkb("rw_ren_before", mem_ren, 1'b1);
    rst_n = 1'b0;
    auto_mem = 1'b0;
    #1;
    all_zero("rw");
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    stray_ack = 1'b1;
    cyc();
    stray_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chkb($sformatf("rw_no_if_rvalid%0d", k), if_rvalid, 1'b0);
      chkb($sformatf("rw_no_d_rvalid%0d", k), d_rvalid, 1'b0);
      chkb($sformatf("rw_no_ren%0d", k), mem_ren, 1'b0);
    end
    auto_mem = 1'b1;
    run_vec("rw_fresh", '{1'b0, 1'b0, 32'h708, 32'h0, 4'hF, 2, 32'h600DF00D, 32'h708, 4'hF, 32'h600DF00D, 32'h600DF00D});

    // Randomized traffic against the reference model.
    if_req = 1'b0; d_req = 1'b0; lat = 1;
    repeat (3) cyc();
    m_busy = 1'b0; m_wins = 0; if_pend = 1'b0; d_pend = 1'b0;
    seen_if = 1'b0; seen_d = 1'b0;
    if_a = 32'h0; d_a = 32'h0; d_w = 1'b0; d_wd = 32'h0; d_m = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      e_ifv = 1'b0;
      e_dv = 1'b0;
      if (m_busy && mem_ack) begin
        m_busy = 1'b0;
        if (m_owner_d) begin e_dv = 1'b1; last_d = m_exp; seen_d = 1'b1; end
        else begin e_ifv = 1'b1; last_if = m_exp; seen_if = 1'b1; end
      end else if (m_busy) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_strobes", 32'({mem_wen, mem_ren}), m_store ? 32'd2 : 32'd1);
        chk("rnd_mem_mask", 32'(mem_mask), 32'(m_mask));
        if (m_store) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chkb("rnd_if_rvalid", if_rvalid, e_ifv);
      chkb("rnd_d_rvalid", d_rvalid, e_dv);
      if (seen_if) chk("rnd_if_rdata", if_rdata, last_if);
      if (seen_d) chk("rnd_d_rdata", d_rdata, last_d);

      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_a = 32'h8000 + 32'($urandom_range(0, 63));
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1'b1;
        d_a = 32'h8000 + 32'($urandom_range(0, 63));
        d_w = 1'($urandom_range(0, 1));
        d_wd = $urandom;
        d_m = 4'($urandom);
      end
      if_req = if_pend; if_addr = if_a;
      d_req = d_pend; d_addr = d_a; d_wen = d_w; d_wdata = d_wd; d_mask = d_m;
      #1;

      e_if = 1'b0;
      e_d = 1'b0;
      if (!m_busy) begin
        if (if_pend && (!d_pend || m_wins >= LIMIT)) e_if = 1'b1;
        else if (d_pend) e_d = 1'b1;
        if (e_if || !if_pend) m_wins = 0;
        else if (e_d && m_wins < LIMIT) m_wins++;
      end
      chkb("rnd_if_gnt", if_gnt, e_if);
      chkb("rnd_d_gnt", d_gnt, e_d);
      if (e_if) begin
        m_busy = 1'b1; m_owner_d = 1'b0; m_store = 1'b0;
        m_addr = {if_a[31:2], 2'b00}; m_mask = 4'hF; m_wdata = 32'h0;
        m_exp = rd_refm(if_a[31:2]);
        if_pend = 1'b0;
        lat = $urandom_range(1, 3);
      end else if (e_d) begin
        m_busy = 1'b1; m_owner_d = 1'b1; m_store = d_w;
        m_addr = {d_a[31:2], 2'b00}; m_mask = d_m; m_wdata = d_wd;
        if (d_w) begin
          refm[d_a[31:2]] = merge(rd_refm(d_a[31:2]), d_wd, d_m);
          m_exp = 32'h0;
        end else begin
          m_exp = rd_refm(d_a[31:2]);
        end
        d_pend = 1'b0;
        lat = $urandom_range(1, 3);
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (6) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
